dma_desc_fetch_mc: RTL

Multi-channel descriptor fetch engine, the parametrised successor to the single-channel fetch path of sg_dma.
- Walks NUM_CH independent linked descriptor lists.
- Arbitrates round-robin for one shared AVMM burst-read master.
- Checks the hardware-ownership bit of each descriptor and follows the next pointer.
- Pushes complete descriptors, tagged with their channel number, to per-channel descriptor FIFOs feeding the descriptor processors.

---
 rtl/dma_desc_fetch_mc_if.sv | 42 ++++
 rtl/dma_desc_fetch_mc.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dma_desc_fetch_mc_if.sv
// Bus bundle for the multi-channel descriptor fetch engine: CSR inputs,
// AVMM burst-read master and descriptor FIFO push side.
interface dma_desc_fetch_mc_if #(
    parameter int NUM_CH     = 4,
    parameter int DESC_WORDS = 4,
    parameter int CH_W       = 2
);
    logic [NUM_CH-1:0]        csr_run_i;
    logic [32*NUM_CH-1:0]     csr_first_pointer_i;
    logic                     dma_desc_fetch_read_o;
    logic [3:0]               dma_desc_fetch_bcount_o;
    logic [31:0]              dma_desc_fetch_addr_o;
    logic                     dma_desc_fetch_waitrequest_i;
    logic [31:0]              dma_desc_fetch_rddata_i;
    logic                     dma_desc_fetch_readdatavalid_i;
    logic                     dma_desc_fifo_wr_o;
    logic [32*DESC_WORDS-1:0] dma_desc_fifo_wrdata_o;
    logic [CH_W-1:0]          dma_desc_fifo_ch_o;
    logic [NUM_CH-1:0]        dma_desc_fifo_full_i;
    logic [NUM_CH-1:0]        dma_chan_active_o;
    logic [NUM_CH-1:0]        dma_chan_done_o;

    modport master (
        input  csr_run_i, csr_first_pointer_i,
        output dma_desc_fetch_read_o, dma_desc_fetch_bcount_o, dma_desc_fetch_addr_o,
        input  dma_desc_fetch_waitrequest_i, dma_desc_fetch_rddata_i,
        input  dma_desc_fetch_readdatavalid_i,
        output dma_desc_fifo_wr_o, dma_desc_fifo_wrdata_o, dma_desc_fifo_ch_o,
        input  dma_desc_fifo_full_i,
        output dma_chan_active_o, dma_chan_done_o
    );

    modport slave (
        output csr_run_i, csr_first_pointer_i,
        input  dma_desc_fetch_read_o, dma_desc_fetch_bcount_o, dma_desc_fetch_addr_o,
        output dma_desc_fetch_waitrequest_i, dma_desc_fetch_rddata_i,
        output dma_desc_fetch_readdatavalid_i,
        input  dma_desc_fifo_wr_o, dma_desc_fifo_wrdata_o, dma_desc_fifo_ch_o,
        output dma_desc_fifo_full_i,
        input  dma_chan_active_o, dma_chan_done_o
    );
endinterface

// File: rtl/dma_desc_fetch_mc.sv
// Multi-channel linked-list descriptor fetcher: round-robin over channels,
// one shared AVMM burst reader, ownership check, push to per-channel FIFOs.
module dma_desc_fetch_mc #(
    parameter int NUM_CH     = 4,
    parameter int DESC_WORDS = 4,
    parameter int CH_W       = 2
) (
    input logic                 clk,
    input logic                 reset,
    dma_desc_fetch_mc_if.master bus
);
    localparam int BW = $clog2(DESC_WORDS);

    typedef enum logic [2:0] {ARB, REQ, DATA, CHK, PUSH} state_t;

    state_t                   state;
    logic [NUM_CH-1:0]        active;
    logic [NUM_CH-1:0]        run_q;
    logic [NUM_CH-1:0]        done;
    logic [NUM_CH-1:0]        elig;
    logic [NUM_CH-1:0]        rise;
    logic [NUM_CH-1:0]        ending;
    logic [31:0]              ptr [NUM_CH];
    logic [31:0]              words [DESC_WORDS];
    logic [CH_W-1:0]          rr;
    logic [CH_W-1:0]          cur;
    logic [CH_W-1:0]          sel;
    logic [CH_W-1:0]          next_rr;
    logic                     found;
    logic [BW-1:0]            beat;
    logic                     read;
    logic [31:0]              addr;
    logic [3:0]               bcount;
    logic                     fifo_wr;
    logic [32*DESC_WORDS-1:0] wrdata;
    logic [CH_W-1:0]          ch;

    assign bus.dma_desc_fetch_read_o   = read;
    assign bus.dma_desc_fetch_bcount_o = bcount;
    assign bus.dma_desc_fetch_addr_o   = addr;
    assign bus.dma_desc_fifo_wr_o      = fifo_wr;
    assign bus.dma_desc_fifo_wrdata_o  = wrdata;
    assign bus.dma_desc_fifo_ch_o      = ch;
    assign bus.dma_chan_active_o       = active;
    assign bus.dma_chan_done_o         = done;

    assign elig    = active & bus.csr_run_i & ~bus.dma_desc_fifo_full_i;
    assign rise    = bus.csr_run_i & ~run_q;
    assign next_rr = (cur == CH_W'(NUM_CH - 1)) ? '0 : cur + CH_W'(1);

    // First eligible channel at or after the RR pointer, wrapping at NUM_CH.
    always_comb begin
        logic [CH_W-1:0] idx;
        found = 1'b0;
        sel   = '0;
        idx   = rr;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!found && elig[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
            idx = (idx == CH_W'(NUM_CH - 1)) ? '0 : idx + CH_W'(1);
        end
    end

    // Channels whose list ends this cycle; a run edge here re-arms them.
    always_comb begin
        ending = '0;
        if (state == CHK && !words[3][31])
            ending[cur] = 1'b1;
        if (state == PUSH && words[0] == '0)
            ending[cur] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ARB;
            active  <= '0;
            run_q   <= '0;
            done    <= '0;
            rr      <= '0;
            cur     <= '0;
            beat    <= '0;
            read    <= 1'b0;
            addr    <= '0;
            bcount  <= '0;
            fifo_wr <= 1'b0;
            wrdata  <= '0;
            ch      <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++)
                ptr[c] <= '0;
            for (int unsigned k = 0; k < DESC_WORDS; k++)
                words[k] <= '0;
        end else begin
            run_q   <= bus.csr_run_i;
            done    <= '0;
            fifo_wr <= 1'b0;
            case (state)
                ARB: begin
                    for (int unsigned c = 0; c < NUM_CH; c++)
                        if (!bus.csr_run_i[c])
                            active[c] <= 1'b0;
                    if (found) begin
                        cur    <= sel;
                        read   <= 1'b1;
                        addr   <= ptr[sel];
                        bcount <= 4'(DESC_WORDS);
                        beat   <= '0;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (!bus.dma_desc_fetch_waitrequest_i) begin
                        read   <= 1'b0;
                        bcount <= '0;
                        state  <= DATA;
                    end
                end
                DATA: begin
                    if (bus.dma_desc_fetch_readdatavalid_i) begin
                        words[beat] <= bus.dma_desc_fetch_rddata_i;
                        if (beat == BW'(DESC_WORDS - 1))
                            state <= CHK;
                        else
                            beat <= beat + BW'(1);
                    end
                end
                CHK: begin
                    if (words[3][31]) begin
                        fifo_wr <= 1'b1;
                        ch      <= cur;
                        for (int unsigned k = 0; k < DESC_WORDS; k++)
                            wrdata[32*k +: 32] <= words[k];
                        state   <= PUSH;
                    end else begin
                        active[cur] <= 1'b0;
                        done[cur]   <= 1'b1;
                        rr          <= next_rr;
                        state       <= ARB;
                    end
                end
                PUSH: begin
                    ptr[cur] <= words[0];
                    if (words[0] == '0) begin
                        active[cur] <= 1'b0;
                        done[cur]   <= 1'b1;
                    end
                    rr    <= next_rr;
                    state <= ARB;
                end
                default: state <= ARB;
            endcase
            // Written last so a run edge overrides an end-of-list clear.
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (rise[c] && (!active[c] || ending[c])) begin
                    ptr[c]    <= bus.csr_first_pointer_i[32*c +: 32];
                    active[c] <= 1'b1;
                end
            end
        end
    end
endmodule
